// File: rtl/control_pkg.sv
// Shared types for the hardwired control sequencer: step states, opcode
// encodings, ALU operation codes and the per-step strobe bundle.
package control_pkg;

  typedef enum logic [3:0] {
    IDLE = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    T7   = 4'd8,
    HALT = 4'd9
  } state_t;

  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_ADDI = 5'b01100;
  localparam logic [4:0] OP_ANDI = 5'b01101;
  localparam logic [4:0] OP_ORI  = 5'b01110;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3
  } alu_op_t;

  // Opcodes grouped by the shape of their execute sequence.
  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_RTYPE,
    CLS_IMM,
    CLS_LDI,
    CLS_LD,
    CLS_ST,
    CLS_HALT
  } op_class_t;

  typedef struct packed {
    logic    pc_out;
    logic    pc_in;
    logic    inc_pc;
    logic    mar_in;
    logic    mdr_in;
    logic    mdr_out;
    logic    ir_in;
    logic    y_in;
    logic    z_in;
    logic    zlow_out;
    logic    c_out;
    logic    read;
    logic    write;
    logic    gra;
    logic    grb;
    logic    grc;
    logic    r_in;
    logic    r_out;
    logic    ba_out;
    logic    run;
    alu_op_t alu_op;
  } strobes_t;

  // Unlisted opcodes fall into CLS_NOP.
  function automatic op_class_t op_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = CLS_RTYPE;
      OP_ADDI, OP_ANDI, OP_ORI:      op_class = CLS_IMM;
      OP_LDI:                        op_class = CLS_LDI;
      OP_LD:                         op_class = CLS_LD;
      OP_ST:                         op_class = CLS_ST;
      OP_HALT:                       op_class = CLS_HALT;
      default:                       op_class = CLS_NOP;
    endcase
  endfunction

  // ALU operation for arithmetic/logic opcodes; address math uses ADD.
  function automatic alu_op_t op_alu(input logic [4:0] op);
    case (op)
      OP_SUB:          op_alu = ALU_SUB;
      OP_AND, OP_ANDI: op_alu = ALU_AND;
      OP_OR, OP_ORI:   op_alu = ALU_OR;
      default:         op_alu = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_step_decode.sv
// Combinational Moore decode of (control step, opcode) into the datapath,
// memory and register-select strobes.
module control_step_decode
  import control_pkg::*;
(
  input  state_t     state,
  input  logic [4:0] opcode,
  output strobes_t   strobes
);

  op_class_t cls;

  // Decode the strobe set for the current step of the current instruction.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    strobes        = '0;
    strobes.alu_op = ALU_ADD;
    cls            = op_class(opcode);
    strobes.run    = (state != IDLE) && (state != HALT);

    case (state)
      T0: begin
        strobes.pc_out = 1'b1;
        strobes.mar_in = 1'b1;
        strobes.inc_pc = 1'b1;
        strobes.z_in   = 1'b1;
      end
      T1: begin
        strobes.zlow_out = 1'b1;
        strobes.pc_in    = 1'b1;
        strobes.read     = 1'b1;
        strobes.mdr_in   = 1'b1;
      end
      T2: begin
        strobes.mdr_out = 1'b1;
        strobes.ir_in   = 1'b1;
      end
      T3: begin
        case (cls)
          CLS_RTYPE, CLS_IMM: begin
            strobes.grb   = 1'b1;
            strobes.r_out = 1'b1;
            strobes.y_in  = 1'b1;
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            strobes.grb    = 1'b1;
            strobes.ba_out = 1'b1;
            strobes.y_in   = 1'b1;
          end
          default: ;
        endcase
      end
      T4: begin
        case (cls)
          CLS_RTYPE: begin
            strobes.grc    = 1'b1;
            strobes.r_out  = 1'b1;
            strobes.z_in   = 1'b1;
            strobes.alu_op = op_alu(opcode);
          end
          CLS_IMM: begin
            strobes.c_out  = 1'b1;
            strobes.z_in   = 1'b1;
            strobes.alu_op = op_alu(opcode);
          end
          CLS_LDI, CLS_LD, CLS_ST: begin
            strobes.c_out = 1'b1;
            strobes.z_in  = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (cls)
          CLS_RTYPE, CLS_IMM, CLS_LDI: begin
            strobes.zlow_out = 1'b1;
            strobes.gra      = 1'b1;
            strobes.r_in     = 1'b1;
          end
          CLS_LD, CLS_ST: begin
            strobes.zlow_out = 1'b1;
            strobes.mar_in   = 1'b1;
          end
          default: ;
        endcase
      end
      T6: begin
        case (cls)
          CLS_LD: begin
            strobes.read   = 1'b1;
            strobes.mdr_in = 1'b1;
          end
          CLS_ST: begin
            strobes.gra    = 1'b1;
            strobes.r_out  = 1'b1;
            strobes.mdr_in = 1'b1;
          end
          default: ;
        endcase
      end
      T7: begin
        case (cls)
          CLS_LD: begin
            strobes.mdr_out = 1'b1;
            strobes.gra     = 1'b1;
            strobes.r_in    = 1'b1;
          end
          CLS_ST: strobes.write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control-step FSM: fetch (T0-T2) followed by an opcode-specific
// execute sequence. Optional macro CTRL_MEM_WAIT_EN makes the memory steps
// (fetch T1, ld T6, st T7) stall until mem_ready.
module control_sequencer
  import control_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] IR_data,
  input  logic                  mem_ready,
  output logic                  PCout,
  output logic                  PCin,
  output logic                  IncPC,
  output logic                  MARin,
  output logic                  MDRin,
  output logic                  MDRout,
  output logic                  IRin,
  output logic                  Yin,
  output logic                  Zin,
  output logic                  Zlowout,
  output logic                  Cout,
  output logic                  Read,
  output logic                  Write,
  output logic                  Gra,
  output logic                  Grb,
  output logic                  Grc,
  output logic                  Rin,
  output logic                  Rout,
  output logic                  BAout,
  output logic [3:0]            alu_op,
  output logic                  Run
);

  state_t     state;
  state_t     state_next;
  logic [4:0] opcode_q;
  logic [4:0] ir_opcode;
  logic [4:0] cur_opcode;
  op_class_t  cur_class;
  logic       mem_wait;
  strobes_t   strobes;
  logic       unused_ir_bits;

  assign ir_opcode      = IR_data[DATA_WIDTH-1 -: 5];
  assign unused_ir_bits = ^IR_data[DATA_WIDTH-6:0];

  // IR is loaded at the end of T2, so T3 decodes it directly; later steps
  // use the copy latched when T3 ends.
  assign cur_opcode = (state == T3) ? ir_opcode : opcode_q;
  assign cur_class  = op_class(cur_opcode);

`ifdef CTRL_MEM_WAIT_EN
  assign mem_wait = !mem_ready &&
                    ((state == T1) ||
                     (state == T6 && cur_class == CLS_LD) ||
                     (state == T7 && cur_class == CLS_ST));
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign mem_wait         = 1'b0;
`endif

  // State register; reset abandons any instruction in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    // NOTE: sequential state is updated with non-blocking assignments so
    // every register samples pre-edge values regardless of block order.
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Opcode latch, loaded once per instruction at the end of T3.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)           opcode_q <= OP_NOP;
    else if (state == T3)   opcode_q <= ir_opcode;
  end

  // Next-step selection, including stalls on memory steps.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: state_next = T0;
      T0:   state_next = T1;
      T1:   if (!mem_wait) state_next = T2;
      T2:   state_next = T3;
      T3: begin
        case (cur_class)
          CLS_HALT: state_next = HALT;
          CLS_NOP:  state_next = T0;
          default:  state_next = T4;
        endcase
      end
      T4:   state_next = T5;
      T5:   state_next = (cur_class == CLS_LD || cur_class == CLS_ST) ? T6 : T0;
      T6:   if (!mem_wait) state_next = T7;
      T7:   if (!mem_wait) state_next = T0;
      HALT: state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  control_step_decode u_decode (
    .state   (state),
    .opcode  (cur_opcode),
    .strobes (strobes)
  );

  // Drive the output ports from the decoded strobe bundle.
  always_comb begin
    PCout   = strobes.pc_out;
    PCin    = strobes.pc_in;
    IncPC   = strobes.inc_pc;
    MARin   = strobes.mar_in;
    MDRin   = strobes.mdr_in;
    MDRout  = strobes.mdr_out;
    IRin    = strobes.ir_in;
    Yin     = strobes.y_in;
    Zin     = strobes.z_in;
    Zlowout = strobes.zlow_out;
    Cout    = strobes.c_out;
    Read    = strobes.read;
    Write   = strobes.write;
    Gra     = strobes.gra;
    Grb     = strobes.grb;
    Grc     = strobes.grc;
    Rin     = strobes.r_in;
    Rout    = strobes.r_out;
    BAout   = strobes.ba_out;
    alu_op  = strobes.alu_op;
    Run     = strobes.run;
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed testbench for control_sequencer. Expected strobe patterns are
// hand-written masks; outputs are sampled on the falling clock edge.
module tb_control_sequencer;

  logic        clock;
  logic        reset_n;
  logic [31:0] IR_data;
  logic        mem_ready;
  logic PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Cout;
  logic Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Run;
  logic [3:0]  alu_op;

  int checks   = 0;
  int failures = 0;
  int rw_conflicts = 0;
  int gr_conflicts = 0;

  localparam logic [23:0] M_PCOUT   = 24'h800000;
  localparam logic [23:0] M_PCIN    = 24'h400000;
  localparam logic [23:0] M_INCPC   = 24'h200000;
  localparam logic [23:0] M_MARIN   = 24'h100000;
  localparam logic [23:0] M_MDRIN   = 24'h080000;
  localparam logic [23:0] M_MDROUT  = 24'h040000;
  localparam logic [23:0] M_IRIN    = 24'h020000;
  localparam logic [23:0] M_YIN     = 24'h010000;
  localparam logic [23:0] M_ZIN     = 24'h008000;
  localparam logic [23:0] M_ZLOWOUT = 24'h004000;
  localparam logic [23:0] M_COUT    = 24'h002000;
  localparam logic [23:0] M_READ    = 24'h001000;
  localparam logic [23:0] M_WRITE   = 24'h000800;
  localparam logic [23:0] M_GRA     = 24'h000400;
  localparam logic [23:0] M_GRB     = 24'h000200;
  localparam logic [23:0] M_GRC     = 24'h000100;
  localparam logic [23:0] M_RIN     = 24'h000080;
  localparam logic [23:0] M_ROUT    = 24'h000040;
  localparam logic [23:0] M_BAOUT   = 24'h000020;
  localparam logic [23:0] M_RUN     = 24'h000010;

  localparam logic [23:0] E_T0 = M_PCOUT | M_MARIN | M_INCPC | M_ZIN | M_RUN;
  localparam logic [23:0] E_T1 = M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN | M_RUN;
  localparam logic [23:0] E_T2 = M_MDROUT | M_IRIN | M_RUN;
  localparam logic [23:0] E_R3 = M_GRB | M_ROUT | M_YIN | M_RUN;
  localparam logic [23:0] E_R4 = M_GRC | M_ROUT | M_ZIN | M_RUN;
  localparam logic [23:0] E_WB = M_ZLOWOUT | M_GRA | M_RIN | M_RUN;
  localparam logic [23:0] E_A3 = M_GRB | M_BAOUT | M_YIN | M_RUN;
  localparam logic [23:0] E_A4 = M_COUT | M_ZIN | M_RUN;
  localparam logic [23:0] E_A5 = M_ZLOWOUT | M_MARIN | M_RUN;

  logic [23:0] vec;
  assign vec = {PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin, Zin, Zlowout,
                Cout, Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, Run, alu_op};

  control_sequencer #(.DATA_WIDTH(32)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .IR_data   (IR_data),
    .mem_ready (mem_ready),
    .PCout     (PCout),
    .PCin      (PCin),
    .IncPC     (IncPC),
    .MARin     (MARin),
    .MDRin     (MDRin),
    .MDRout    (MDRout),
    .IRin      (IRin),
    .Yin       (Yin),
    .Zin       (Zin),
    .Zlowout   (Zlowout),
    .Cout      (Cout),
    .Read      (Read),
    .Write     (Write),
    .Gra       (Gra),
    .Grb       (Grb),
    .Grc       (Grc),
    .Rin       (Rin),
    .Rout      (Rout),
    .BAout     (BAout),
    .alu_op    (alu_op),
    .Run       (Run)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [23:0] exp);
    @(negedge clock);
    check(tag, {8'h0, vec}, {8'h0, exp});
  endtask

  // Fetch steps; the new instruction word is presented once T0 is confirmed.
  task automatic fetch(input string tag, input logic [31:0] ir);
    step({tag, "_t0"}, E_T0);
    IR_data = ir;
    step({tag, "_t1"}, E_T1);
    step({tag, "_t2"}, E_T2);
  endtask

  // Protocol invariants sampled every cycle while out of reset.
  always @(negedge clock) begin
    if (reset_n) begin
      if (Read && Write) rw_conflicts++;
      if ($countones({Gra, Grb, Grc}) > 1) gr_conflicts++;
    end
  end

  initial begin
    reset_n   = 1'b1;
    IR_data   = 32'h0;
    mem_ready = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check("reset_idle", {8'h0, vec}, 32'h0);
    reset_n = 1'b1;
    #1 check("release_idle", {8'h0, vec}, 32'h0);

    // add R1,R2,R3: ALU ADD on T4, 6-cycle period
    fetch("add", 32'h18918000);
    step("add_t3", E_R3);
    step("add_t4", E_R4 | 24'd0);
    step("add_t5", E_WB);

    // sub: ALU SUB
    fetch("sub", 32'h20918000);
    step("sub_t3", E_R3);
    step("sub_t4", E_R4 | 24'd1);
    step("sub_t5", E_WB);

    // or: ALU OR
    fetch("or", 32'h58918000);
    step("or_t3", E_R3);
    step("or_t4", E_R4 | 24'd3);
    step("or_t5", E_WB);

    // andi: constant operand, ALU AND
    fetch("andi", 32'h68900007);
    step("andi_t3", E_R3);
    step("andi_t4", E_A4 | 24'd2);
    step("andi_t5", E_WB);

    // ldi: base+offset written back
    fetch("ldi", 32'h08900005);
    step("ldi_t3", E_A3);
    step("ldi_t4", E_A4);
    step("ldi_t5", E_WB);

    // ld R1,5(R2): 8-cycle period
    fetch("ld", 32'h00900005);
    step("ld_t3", E_A3);
    step("ld_t4", E_A4);
    step("ld_t5", E_A5);
    step("ld_t6", M_READ | M_MDRIN | M_RUN);
    step("ld_t7", M_MDROUT | M_GRA | M_RIN | M_RUN);

    // st R3,0x20
    fetch("st", 32'h11800020);
    step("st_t3", E_A3);
    step("st_t4", E_A4);
    step("st_t5", E_A5);
    step("st_t6", M_GRA | M_ROUT | M_MDRIN | M_RUN);
    step("st_t7", M_WRITE | M_RUN);

    // nop and an unlisted opcode: empty T3, 4-cycle period
    fetch("nop", 32'hD0000000);
    step("nop_t3", M_RUN);
    fetch("undef", 32'hF8000000);
    step("undef_t3", M_RUN);

`ifdef CTRL_MEM_WAIT_EN
    // Fetch read stalls while mem_ready is low for three cycles.
    step("wait_t0", E_T0);
    IR_data   = 32'hD0000000;
    mem_ready = 1'b0;
    step("wait_t1a", E_T1);
    step("wait_t1b", E_T1);
    step("wait_t1c", E_T1);
    step("wait_t1d", E_T1);
    mem_ready = 1'b1;
    step("wait_t2", E_T2);
    step("wait_t3", M_RUN);
`endif

    // halt: parks in HALT with everything low
    fetch("halt", 32'hD8000000);
    step("halt_t3", M_RUN);
    for (int i = 0; i < 20; i++) step($sformatf("halt_hold%0d", i), 24'h0);

    // Asynchronous reset in the middle of an add
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    fetch("arst", 32'h18918000);
    step("arst_t3", E_R3);
    step("arst_t4", E_R4);
    #2 reset_n = 1'b0;
    #1 check("arst_async", {8'h0, vec}, 32'h0);
    @(negedge clock);
    check("arst_held", {8'h0, vec}, 32'h0);
    reset_n = 1'b1;
    step("arst_restart_t0", E_T0);

    check("read_write_exclusive", rw_conflicts, 0);
    check("gr_select_onehot", gr_conflicts, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
